wr_arb: RTL and testbench
=========================

Name: wr_arb

Overview:
- Two-requester write scheduler that shares one 16-bit downstream write port (list buffer / capture FIFO) between two strobe-style sources, each driving a `q`/`wr` pair.
- Sources cannot be stalled, so each input is absorbed into a small per-source FIFO.
- The arbiter drains both FIFOs round-robin into a registered output gated by downstream `out_ready`.
- Overflow is reported per source through a sticky flag and a saturating drop counter.

Parameters:
- DEPTH, 8, per-source FIFO depth in words; power of 2, minimum 2.
- AW, 3, FIFO address width; must equal log2(DEPTH).
- DROP_W, 8, width of each saturating drop counter.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_q  in  16  source A data.
- a_wr  in  1  source A write strobe; one word per high cycle.
- b_q  in  16  source B data.
- b_wr  in  1  source B write strobe.
- out_ready  in  1  downstream can accept words.
- ovf_clr  in  1  clears both sticky flags and both drop counters.
- out_q  out  16  granted word.
- out_wr  out  1  one-cycle write pulse qualifying out_q.
- out_src  out  1  0 = word from A, 1 = word from B.
- a_ovf  out  1  sticky: A word dropped.
- b_ovf  out  1  sticky: B word dropped.
- a_drop  out  DROP_W  count of A words dropped; saturating.
- b_drop  out  DROP_W  count of B words dropped; saturating.

Behaviour:
- Reset:
  - out_q = 0, out_wr = 0, out_src = 0.
  - Both ovf flags = 0, both drop counters = 0.
  - Both FIFOs empty; last-grant register = B, so A wins the first tie.
  - Reset asserted mid-operation discards all buffered words immediately. No out_wr is produced in the cycle after reset deasserts.
- FIFO write:
  - x_wr high with the FIFO not full (registered count < DEPTH) stores x_q.
  - x_wr high with the FIFO full and no pop in the same cycle drops the word, sets x_ovf and increments x_drop. x_drop saturates at all-ones.
  - Full FIFO with a pop in the same cycle: the write is accepted and the count is unchanged.
- Grant, evaluated every cycle with out_ready high:
  - Both FIFOs non-empty: grant the source not granted last.
  - Exactly one non-empty: grant that source.
  - None non-empty: no grant.
  - A grant pops the head word. The last-grant register updates only on a grant.
- Output is registered, one word per cycle maximum:
  - Grant at cycle N gives out_wr = 1 at N+1, with out_q = popped word and out_src = granted source.
  - No grant gives out_wr = 0; out_q and out_src hold their previous values.
- Latency: x_wr at cycle N with an empty FIFO and out_ready high gives out_wr at N+2.
- Backpressure:
  - out_ready low at cycle N means no grant at N.
  - Downstream must still accept the one word already issued (out_wr at N from a grant at N-1).
- Throughput: 1 word/cycle aggregate. Under sustained dual load each source gets 1 word per 2 cycles.
- ovf_clr has priority over a simultaneous drop in the same cycle: flag and counter end at 0.
- Pointer wrap: read/write pointers are AW bits and wrap modulo DEPTH. The count is AW+1 bits.

Optional Feature:
- Macro: WR_ARB_STRICT_PRIO_EN.
- Defined: fixed priority. A always wins when non-empty; B is granted only when A is empty. The last-grant register is not used.
- Undefined: round-robin as described in Behaviour.
- Ports, latency and overflow behaviour are identical in both builds.

Decomposition:
- Shared package/include `wr_arb_pkg`:
  - SRC_A = 1'b0, SRC_B = 1'b1.
  - Default DEPTH/AW/DROP_W constants.
- One sub-module, `wr_arb_fifo`:
  - Synchronous single-clock FIFO, DEPTH×16, with count, full and empty outputs.
  - Drop-on-full flag plus saturating drop counter.
  - Instantiated twice.
- Grant logic and output register stay in `wr_arb`.

Test Plan:
- Single source: a_wr pulses 0x0101, 0x0202 at cycles 10 and 11, out_ready = 1 → out_wr at 12 and 13 with out_q 0x0101, 0x0202, out_src = 0, b_drop = 0.
- Dual tie: both FIFOs preloaded with 4 words (A: 0xA0..A3, B: 0xB0..B3), then out_ready raised → out_src sequence 0,1,0,1,0,1,0,1; out_q A0,B0,A1,B1…; 8 consecutive out_wr.
- Overflow: out_ready = 0, 10 back-to-back a_wr (DEPTH = 8) → FIFO holds first 8 words, a_ovf = 1, a_drop = 2. Pulse ovf_clr → a_ovf = 0, a_drop = 0. A drop in the same cycle as ovf_clr still leaves a_drop = 0.
- Full with simultaneous push/pop: A FIFO full, out_ready = 1, a_wr every cycle for 20 cycles → zero drops, all 20 new words emitted in order.
- Backpressure: out_ready dropped for 5 cycles while streaming → exactly one out_wr after the drop, none for the remainder, no word lost or duplicated.
- Reset mid-stream: rst pulsed with 3 words buffered → out_wr = 0 and FIFOs empty after release. The next tie grants A first. The WR_ARB_STRICT_PRIO_EN build rerun of the dual-tie scenario gives out_src 0,0,0,0,1,1,1,1.

Source files
------------

// File: rtl/wr_arb_pkg.sv
// Shared constants and types for the two-source write arbiter.
package wr_arb_pkg;

  localparam int DATA_W     = 16;
  localparam int DEPTH_DEF  = 8;
  localparam int AW_DEF     = 3;
  localparam int DROP_W_DEF = 8;

  // Source encoding used on out_src and in the last-grant register.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef logic [DATA_W-1:0] word_t;

  // Round-robin pick when both sources hold data: favour the one not served last.
  function automatic logic rr_pick(input logic last_src);
    return (last_src == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/wr_arb_fifo.sv
// Per-source FIFO that absorbs an unstallable write strobe.
// Words arriving while full (and not draining this cycle) are dropped and
// reported through a sticky flag and a saturating drop counter.
module wr_arb_fifo
  import wr_arb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = AW_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i,
  input  word_t             d_i,
  input  logic              pop_i,
  input  logic              ovf_clr_i,
  output word_t             head_o,
  output logic [AW:0]       count_o,
  output logic              ovf_o,
  output logic [DROP_W-1:0] drop_o
);

  word_t             mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic full, empty, pop_ok, push_ok, drop_now;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_ok   = pop_i & ~empty;
  assign push_ok  = wr_i & (~full | pop_ok);
  assign drop_now = wr_i & full & ~pop_ok;

  // Next-state for pointers, occupancy and overflow bookkeeping.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    // Clear wins over a coincident drop.
    if (ovf_clr_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop_now) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
  end

  // Control state register; reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= d_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign drop_o  = drop_q;

endmodule

// File: rtl/wr_arb.sv
// Two-source write scheduler sharing one 16-bit downstream write port.
// Each source feeds its own FIFO; the FIFOs are drained one word per cycle
// into a registered output, gated by out_ready.
// Build option: define WR_ARB_STRICT_PRIO_EN for fixed priority (A over B);
// otherwise sources alternate round-robin when both hold data.
module wr_arb
  import wr_arb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = AW_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       a_q,
  input  logic              a_wr,
  input  logic [15:0]       b_q,
  input  logic              b_wr,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic [15:0]       out_q,
  output logic              out_wr,
  output logic              out_src,
  output logic              a_ovf,
  output logic              b_ovf,
  output logic [DROP_W-1:0] a_drop,
  output logic [DROP_W-1:0] b_drop
);

  logic [1:0]        wr_v, pop_v, ne_v, ovf_v;
  word_t             din_v   [2];
  word_t             head_v  [2];
  logic [AW:0]       count_v [2];
  logic [DROP_W-1:0] drop_v  [2];

  assign wr_v     = {b_wr, a_wr};
  assign din_v[0] = a_q;
  assign din_v[1] = b_q;

  // Index 0 is source A, index 1 is source B (matches SRC_A / SRC_B).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      wr_arb_fifo #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DROP_W (DROP_W)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (wr_v[gi]),
        .d_i       (din_v[gi]),
        .pop_i     (pop_v[gi]),
        .ovf_clr_i (ovf_clr),
        .head_o    (head_v[gi]),
        .count_o   (count_v[gi]),
        .ovf_o     (ovf_v[gi]),
        .drop_o    (drop_v[gi])
      );
      assign ne_v[gi] = (count_v[gi] != '0);
    end
  endgenerate

  logic  gnt_v;
  logic  gnt_src;
  word_t out_q_q;
  logic  out_wr_q;
  logic  out_src_q;

`ifndef WR_ARB_STRICT_PRIO_EN
  logic last_q;
`endif

  // Grant decision for this cycle; a grant pops the chosen FIFO's head.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_src = SRC_A;
    if (out_ready) begin
`ifdef WR_ARB_STRICT_PRIO_EN
      if (ne_v[0]) begin
        gnt_v   = 1'b1;
        gnt_src = SRC_A;
      end else if (ne_v[1]) begin
        gnt_v   = 1'b1;
        gnt_src = SRC_B;
      end
`else
      if (ne_v[0] && ne_v[1]) begin
        gnt_v   = 1'b1;
        gnt_src = rr_pick(last_q);
      end else if (ne_v[0]) begin
        gnt_v   = 1'b1;
        gnt_src = SRC_A;
      end else if (ne_v[1]) begin
        gnt_v   = 1'b1;
        gnt_src = SRC_B;
      end
`endif
    end
  end

  assign pop_v[0] = gnt_v & (gnt_src == SRC_A);
  assign pop_v[1] = gnt_v & (gnt_src == SRC_B);

`ifndef WR_ARB_STRICT_PRIO_EN
  // Last-grant register; starts at B so A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_q <= SRC_B;
    else if (gnt_v) last_q <= gnt_src;
  end
`endif

  // Output register: pulse out_wr for one cycle per grant, hold data otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q_q   <= '0;
      out_wr_q  <= 1'b0;
      out_src_q <= SRC_A;
    end else begin
      out_wr_q <= gnt_v;
      if (gnt_v) begin
        out_q_q   <= (gnt_src == SRC_B) ? head_v[1] : head_v[0];
        out_src_q <= gnt_src;
      end
    end
  end

  assign out_q   = out_q_q;
  assign out_wr  = out_wr_q;
  assign out_src = out_src_q;
  assign a_ovf   = ovf_v[0];
  assign b_ovf   = ovf_v[1];
  assign a_drop  = drop_v[0];
  assign b_drop  = drop_v[1];

endmodule

// File: tb/tb_wr_arb.sv
// Scoreboard bench for wr_arb: scenarios push hand-computed expected words
// (source, data, optional cycle) into a queue; a negedge monitor checks
// every out_wr pulse against the queue head.
module tb_wr_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a_q = '0;
  logic        a_wr = 1'b0;
  logic [15:0] b_q = '0;
  logic        b_wr = 1'b0;
  logic        out_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] out_q;
  logic        out_wr;
  logic        out_src;
  logic        a_ovf, b_ovf;
  logic [7:0]  a_drop, b_drop;

  wr_arb dut (
    .clk       (clk),
    .rst       (rst),
    .a_q       (a_q),
    .a_wr      (a_wr),
    .b_q       (b_q),
    .b_wr      (b_wr),
    .out_ready (out_ready),
    .ovf_clr   (ovf_clr),
    .out_q     (out_q),
    .out_wr    (out_wr),
    .out_src   (out_src),
    .a_ovf     (a_ovf),
    .b_ovf     (b_ovf),
    .a_drop    (a_drop),
    .b_drop    (b_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        src;
    logic [15:0] d;
    int          cyc;   // -1 = cycle not checked
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the next expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_wr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_wr actual q=%h src=%0d expected no write (cyc %0d)",
                 out_q, out_src, cyc);
      end else begin
        e = sb.pop_front();
        $display("xfer cyc=%0d src=%0d q=%h", cyc, out_src, out_q);
        chk("out_q", 32'(out_q), 32'(e.d));
        chk("out_src", 32'(out_src), 32'(e.src));
        if (e.cyc >= 0) chk("out_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic src, input logic [15:0] d, input int c);
    exp_t e;
    e.src = src;
    e.d   = d;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Wait (bounded) for all expected words, then idle to catch extra writes.
  task automatic drain(input string nm, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk({nm, "_pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  int R;
  int S;

  initial begin
    // ---------------- reset state ----------------
    step(); step(); step();
    chk("rst_out_q", 32'(out_q), 32'd0);
    chk("rst_out_wr", 32'(out_wr), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_a_ovf", 32'(a_ovf), 32'd0);
    chk("rst_b_ovf", 32'(b_ovf), 32'd0);
    chk("rst_a_drop", 32'(a_drop), 32'd0);
    chk("rst_b_drop", 32'(b_drop), 32'd0);
    rst = 1'b0;
    step();

    // ---------------- single source, latency N+2 ----------------
    out_ready = 1'b1;
    R = cyc;
    push_exp(1'b0, 16'h0101, R + 2);
    push_exp(1'b0, 16'h0202, R + 3);
    a_wr = 1'b1; a_q = 16'h0101;
    step();
    a_q = 16'h0202;
    step();
    a_wr = 1'b0;
    drain("single", 10);
    chk("single_b_drop", 32'(b_drop), 32'd0);

    // ---------------- dual tie from reset ----------------
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a_wr = 1'b1; a_q = 16'h00A0 + 16'(i);
      b_wr = 1'b1; b_q = 16'h00B0 + 16'(i);
      step();
    end
    a_wr = 1'b0; b_wr = 1'b0;
    step();
    out_ready = 1'b1;
    R = cyc;
`ifdef WR_ARB_STRICT_PRIO_EN
    for (int k = 0; k < 4; k++) push_exp(1'b0, 16'h00A0 + 16'(k), R + 1 + k);
    for (int k = 0; k < 4; k++) push_exp(1'b1, 16'h00B0 + 16'(k), R + 5 + k);
`else
    for (int k = 0; k < 4; k++) begin
      push_exp(1'b0, 16'h00A0 + 16'(k), R + 1 + 2 * k);
      push_exp(1'b1, 16'h00B0 + 16'(k), R + 2 + 2 * k);
    end
`endif
    drain("dual_tie", 20);

    // ---------------- overflow and clear priority ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_wr = 1'b1; a_q = 16'h3000 + 16'(i);
      step();
    end
    a_wr = 1'b0;
    chk("ovf_a_ovf", 32'(a_ovf), 32'd1);
    chk("ovf_a_drop", 32'(a_drop), 32'd2);
    chk("ovf_b_ovf", 32'(b_ovf), 32'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_a_ovf", 32'(a_ovf), 32'd0);
    chk("clr_a_drop", 32'(a_drop), 32'd0);
    a_wr = 1'b1; a_q = 16'h3FFF; ovf_clr = 1'b1;
    step();
    a_wr = 1'b0; ovf_clr = 1'b0;
    chk("clr_vs_drop_a_ovf", 32'(a_ovf), 32'd0);
    chk("clr_vs_drop_a_drop", 32'(a_drop), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_exp(1'b0, 16'h3000 + 16'(k), -1);
    drain("ovf_drain", 20);

    // ---------------- drop counter saturation ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 8 + 260; i++) begin
      a_wr = 1'b1; a_q = 16'h4000 + 16'(i);
      step();
    end
    a_wr = 1'b0;
    chk("sat_a_drop", 32'(a_drop), 32'hFF);
    chk("sat_a_ovf", 32'(a_ovf), 32'd1);
    chk("sat_b_drop", 32'(b_drop), 32'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_exp(1'b0, 16'h4000 + 16'(k), -1);
    drain("sat_drain", 20);

    // ---------------- full FIFO with simultaneous push/pop ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_wr = 1'b1; a_q = 16'h6000 + 16'(i);
      step();
    end
    out_ready = 1'b1;
    R = cyc;
    for (int k = 0; k < 8; k++)  push_exp(1'b0, 16'h6000 + 16'(k), R + 1 + k);
    for (int j = 0; j < 20; j++) push_exp(1'b0, 16'h6100 + 16'(j), R + 9 + j);
    for (int j = 0; j < 20; j++) begin
      a_wr = 1'b1; a_q = 16'h6100 + 16'(j);
      step();
    end
    a_wr = 1'b0;
    drain("full_pushpop", 20);
    chk("full_pushpop_a_drop", 32'(a_drop), 32'd0);
    chk("full_pushpop_a_ovf", 32'(a_ovf), 32'd0);

    // ---------------- backpressure while streaming ----------------
    S = cyc;
    for (int k = 0; k < 12; k++)
      push_exp(1'b0, 16'h5000 + 16'(k), (k < 3) ? (S + k + 2) : (S + k + 7));
    for (int i = 0; i < 12; i++) begin
      a_wr = 1'b1; a_q = 16'h5000 + 16'(i);
      out_ready = !(i >= 4 && i <= 8);
      step();
    end
    a_wr = 1'b0;
    out_ready = 1'b1;
    drain("backpressure", 20);

    // ---------------- reset mid-stream ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_wr = 1'b1; a_q = 16'h7000 + 16'(i);
      step();
    end
    a_wr = 1'b0;
    rst = 1'b1;
    #2;
    chk("midrst_out_q", 32'(out_q), 32'd0);
    chk("midrst_out_wr", 32'(out_wr), 32'd0);
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_out_wr", 32'(out_wr), 32'd0);
    for (int i = 0; i < 5; i++) step();   // buffered words must not reappear
    out_ready = 1'b0;
    a_wr = 1'b1; a_q = 16'h7A00;
    b_wr = 1'b1; b_q = 16'h7B00;
    step();
    a_wr = 1'b0; b_wr = 1'b0;
    out_ready = 1'b1;
    R = cyc;
    push_exp(1'b0, 16'h7A00, R + 1);
    push_exp(1'b1, 16'h7B00, R + 2);
    drain("post_rst_tie", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
